// File: rtl/i2d_if_pkg.sv
// Shared constants and types for the i2d instruction fetch stage.
// Holds the NOP bubble word, reset vector, queue depth and fetch FSM state codes.
package i2d_if_pkg;

  localparam logic [5:0]  I2D_NOP_OPCODE = 6'h3F;
  localparam logic [31:0] I2D_NOP_WORD   = {I2D_NOP_OPCODE, 26'h0};
  localparam logic [31:0] I2D_RESET_VEC  = 32'h0000_0000;
  localparam int unsigned QDEPTH         = 2;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_DROP = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } if_entry_t;

endpackage

// File: rtl/i2d_if_queue.sv
// Two-entry prefetch FIFO holding {pc, instruction} pairs for the fetch stage.
// One-bit read/write pointers toggle on pop/push; clr empties the queue and overrides both.
module i2d_if_queue
  import i2d_if_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clr,
  input  if_entry_t  din,
  output logic [1:0] count,
  output if_entry_t  head
);

  if_entry_t ent0;
  if_entry_t ent1;
  logic      wr_ptr;
  logic      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      ent0   <= '0;
      ent1   <= '0;
    end else if (clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
        if (wr_ptr) ent1 <= din;
        else        ent0 <= din;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = rd_ptr ? ent1 : ent0;

endmodule

// File: rtl/i2d_if.sv
// Instruction fetch stage: fetch PC, req/ack memory handshake and a 2-entry prefetch queue
// feeding decode. Redirect flushes the queue and drops any in-flight read.
module i2d_if
  import i2d_if_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = I2D_RESET_VEC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  logic [1:0]  rst_sync;
  logic        sys_rst_n;
  if_state_t   state;
  logic [31:0] fetch_pc;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        push;
  logic        pop;
  if_entry_t   head;
  if_entry_t   din;

  // Assertion is immediate; release is aligned to clk through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign sys_rst_n = rst_sync[1];

  assign if_valid   = (count != 2'd0);
  assign pop        = if_valid & ~stall & ~redirect;
  assign push       = (state == IF_REQ) & im_ack & ~redirect;
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  assign din        = '{pc: fetch_pc, ins: im_rdata};

  i2d_if_queue u_queue (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .push  (push),
    .pop   (pop),
    .clr   (redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );

  // Redirect wins over ack; an outstanding unacked read must still be drained in DROP.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IF_IDLE;
      fetch_pc <= RESET_VEC;
      im_req   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      im_req   <= 1'b0;
      state    <= (state != IF_IDLE && !im_ack) ? IF_DROP : IF_IDLE;
    end else begin
      unique case (state)
        IF_IDLE: begin
          if (count < 2'(QDEPTH)) begin
            state  <= IF_REQ;
            im_req <= 1'b1;
          end
        end
        IF_REQ: begin
          if (im_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_next < 2'(QDEPTH)) begin
              state  <= IF_REQ;
              im_req <= 1'b1;
            end else begin
              state  <= IF_IDLE;
              im_req <= 1'b0;
            end
          end
        end
        IF_DROP: begin
          if (im_ack) state <= IF_IDLE;
        end
        default: begin
          state  <= IF_IDLE;
          im_req <= 1'b0;
        end
      endcase
    end
  end

  assign im_addr = fetch_pc;
  assign if_ins  = if_valid ? head.ins : I2D_NOP_WORD;
  assign if_pc   = if_valid ? head.pc  : 32'h0;

endmodule

// File: tb/tb_i2d_if.sv
// Directed bench for i2d_if: streaming fetch, stall, slow memory, redirect/drop,
// redirect coincident with ack, async reset pulse and PC wrap.
module tb_i2d_if;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic        if_valid;

  int checks = 0;
  int errors = 0;
  int mem_delay = 0;
  bit pend = 1'b0;
  int cnt = 0;
  logic [31:0] paddr = '0;

  i2d_if #(.RESET_VEC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_ins      (if_ins),
    .if_pc       (if_pc),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;
  endfunction

  // Memory: latches a request, waits mem_delay cycles, then acks for one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      pend   = 1'b0;
      im_ack = 1'b0;
    end else begin
      if (!pend && im_req) begin
        pend  = 1'b1;
        paddr = im_addr;
        cnt   = mem_delay;
      end
      if (pend) begin
        if (cnt == 0) begin
          im_ack   = 1'b1;
          im_rdata = memw(paddr);
          pend     = 1'b0;
        end else begin
          im_ack = 1'b0;
          cnt--;
        end
      end else begin
        im_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (im_req !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk(tag, im_req, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    chk("rst_req", im_req, 32'd0);
    chk("rst_addr", im_addr, 32'h0);
    chk("rst_valid", if_valid, 32'd0);
    chk("rst_ins", if_ins, NOP);
    chk("rst_pc", if_pc, 32'h0);
    rst = 1'b1;

    // 1: zero-wait streaming
    wait_req("s1_req");
    chk("s1_addr0", im_addr, 32'h0);
    chk("s1_novalid", if_valid, 32'd0);
    step();
    chk("s1_valid0", if_valid, 32'd1);
    chk("s1_pc0", if_pc, 32'h0);
    chk("s1_ins0", if_ins, memw(32'h0));
    chk("s1_addr4", im_addr, 32'h4);
    step();
    chk("s1_pc4", if_pc, 32'h4);
    chk("s1_ins4", if_ins, memw(32'h4));
    chk("s1_addr8", im_addr, 32'h8);
    step();
    chk("s1_pc8", if_pc, 32'h8);
    chk("s1_addr12", im_addr, 32'hC);

    // 2: stall for 6 cycles fills the queue and freezes the head
    stall = 1'b1;
    step();
    chk("s2_valid", if_valid, 32'd1);
    chk("s2_pc", if_pc, 32'h8);
    chk("s2_noreq", im_req, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s2_hold_pc", if_pc, 32'h8);
      chk("s2_hold_noreq", im_req, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("s2_pc12_valid", if_valid, 32'd1);
    chk("s2_pc12", if_pc, 32'hC);
    chk("s2_ins12", if_ins, memw(32'hC));
    step();
    chk("s2_bubble", if_valid, 32'd0);
    chk("s2_req16", im_req, 32'd1);
    chk("s2_addr16", im_addr, 32'h10);
    step();
    chk("s2_pc16", if_pc, 32'h10);
    chk("s2_addr20", im_addr, 32'h14);
    mem_delay = 3;

    // 3: three wait states on memory
    step();
    chk("s3_pc20", if_pc, 32'h14);
    chk("s3_addr24", im_addr, 32'h18);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_bub_valid", if_valid, 32'd0);
      chk("s3_bub_ins", if_ins, NOP);
      chk("s3_bub_pc", if_pc, 32'h0);
      chk("s3_addr_stable", im_addr, 32'h18);
      chk("s3_req_held", im_req, 32'd1);
    end
    step();
    chk("s3_pc24", if_pc, 32'h18);
    chk("s3_ins24", if_ins, memw(32'h18));
    chk("s3_addr28", im_addr, 32'h1C);

    // 4: redirect with the read for 28 still outstanding
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    mem_delay = 0;
    chk("s4_drop_noreq", im_req, 32'd0);
    chk("s4_flush", if_valid, 32'd0);
    chk("s4_newpc", im_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_no_stale", if_valid, 32'd0);
      chk("s4_wait_noreq", im_req, 32'd0);
    end
    step();
    chk("s4_req", im_req, 32'd1);
    chk("s4_addr", im_addr, 32'h100);
    step();
    chk("s4_valid", if_valid, 32'd1);
    chk("s4_pc", if_pc, 32'h100);
    chk("s4_ins", if_ins, memw(32'h100));

    // 5: redirect on the same cycle as ack and pop; low bits of target ignored
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    chk("s5_empty", if_valid, 32'd0);
    chk("s5_ins_nop", if_ins, NOP);
    chk("s5_noreq", im_req, 32'd0);
    chk("s5_addr", im_addr, 32'h100);
    step();
    chk("s5_req", im_req, 32'd1);
    chk("s5_req_addr", im_addr, 32'h100);
    step();
    chk("s5_pc", if_pc, 32'h100);
    chk("s5_ins", if_ins, memw(32'h100));

    // 6: async reset pulse between edges, then PC wrap
    rst = 1'b0;
    #1;
    chk("s6_rst_req", im_req, 32'd0);
    chk("s6_rst_addr", im_addr, 32'h0);
    chk("s6_rst_valid", if_valid, 32'd0);
    chk("s6_rst_ins", if_ins, NOP);
    chk("s6_rst_pc", if_pc, 32'h0);
    #2;
    rst = 1'b1;
    wait_req("s6_req");
    chk("s6_addr0", im_addr, 32'h0);
    step();
    chk("s6_pc0", if_pc, 32'h0);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    stall = 1'b0;
    redirect = 1'b0;
    chk("s6_stall_redir", if_valid, 32'd0);
    chk("s6_wrap_target", im_addr, 32'hFFFF_FFFC);
    wait_req("s6_wrap_req");
    chk("s6_wrap_addr", im_addr, 32'hFFFF_FFFC);
    step();
    chk("s6_pc_top", if_pc, 32'hFFFF_FFFC);
    chk("s6_ins_top", if_ins, memw(32'hFFFF_FFFC));
    chk("s6_wrapped", im_addr, 32'h0);
    step();
    chk("s6_pc_wrap0", if_pc, 32'h0);
    chk("s6_ins_wrap0", if_ins, memw(32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
